// File: rtl/rf_scan_pkg.sv
// rtl/rf_scan_pkg.sv - shared types, register map and field layout for the RF switch scanner
package rf_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Register offsets relative to BASE
    localparam logic [7:0] OFS_CTRL  = 8'd0;
    localparam logic [7:0] OFS_DWELL = 8'd1;
    localparam logic [7:0] OFS_BLANK = 8'd2;
    localparam logic [7:0] OFS_TABLE = 8'd3;
    localparam logic [7:0] OFS_IDLE  = 8'd4;

    // Field positions and widths
    localparam int PAT_W            = 10;
    localparam int IDX_W            = 4;
    localparam int CNT_W            = 16;
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_LAST_LSB    = 4;
    localparam int TBL_IDX_LSB      = 16;

endpackage

// File: rtl/rf_scan_table.sv
// rtl/rf_scan_table.sv - pattern table: one write port, one combinational read port
module rf_scan_table
    import rf_scan_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [PAT_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [PAT_W-1:0] o_rd_data
);

    logic [PAT_W-1:0] r_mem [NUM_ENTRIES];

    // Write port; an address at or beyond the table depth matches no entry and is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (i_wr_addr == IDX_W'(i)) r_mem[i] <= i_wr_data;
            end
        end
    end

    // Combinational read mux; out-of-range addresses read as zero
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i_rd_addr == IDX_W'(i)) o_rd_data = r_mem[i];
        end
    end

endmodule

// File: rtl/rf_switch_scanner.sv
// rtl/rf_switch_scanner.sv - RF switch scan sequencer feeding the ATR receive pattern
module rf_switch_scanner
    import rf_scan_pkg::*;
#(
    parameter logic [7:0]       BASE         = 8'd0,
    parameter int               NUM_ENTRIES  = 8,
    parameter logic [PAT_W-1:0] DEFAULT_IDLE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             run,
    output logic [PAT_W-1:0] sw_out,
    output logic             step_stb,
    output logic             wrap_stb,
    output logic             blank,
    output logic             active,
    output logic [31:0]      rb_status
);

    // Settings registers
    logic             r_enable;
    logic             r_one_shot;
    logic [IDX_W-1:0] r_last_idx;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_blank_len;
    logic [PAT_W-1:0] r_idle_pat;

    // Sequencer state
    logic             r_run_d;
    scan_state_t      r_state;
    logic [IDX_W-1:0] r_index;
    logic [PAT_W-1:0] r_sw;
    logic             r_step;
    logic             r_wrap;
    logic             r_blank;
    logic             r_active;
    logic [CNT_W-1:0] r_dwell_cnt;
    logic [CNT_W-1:0] r_blank_cnt;

    // Next-state values
    scan_state_t      w_state_nxt;
    logic [IDX_W-1:0] w_index_nxt;
    logic [PAT_W-1:0] w_sw_nxt;
    logic             w_step_nxt;
    logic             w_wrap_nxt;
    logic             w_blank_nxt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] w_bcnt_nxt;
    logic             w_load;

    logic [IDX_W-1:0] w_last;
    logic [IDX_W-1:0] w_rd_idx;
    logic [PAT_W-1:0] w_rd_data;
    logic [CNT_W-1:0] w_dwell_load;
    logic             w_halt;
    logic             w_tbl_we;
    logic             w_unused_data;

    assign w_tbl_we      = set_stb && (set_addr == BASE + OFS_TABLE);
    assign w_unused_data = ^set_data[31:20];
    assign w_last        = (r_last_idx > IDX_W'(NUM_ENTRIES - 1)) ? IDX_W'(NUM_ENTRIES - 1) : r_last_idx;
    assign w_dwell_load  = (r_dwell == '0) ? '0 : r_dwell - CNT_W'(1);
    assign w_halt        = !r_enable || !r_run_d;
    // Entry presented by the next step: first entry on start, else advance or wrap
    assign w_rd_idx      = (r_state == ST_SCAN && r_index < w_last) ? r_index + IDX_W'(1) : '0;

    rf_scan_table #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_wr_en  (w_tbl_we),
        .i_wr_addr(set_data[TBL_IDX_LSB +: IDX_W]),
        .i_wr_data(set_data[PAT_W-1:0]),
        .i_rd_addr(w_rd_idx),
        .o_rd_data(w_rd_data)
    );

    // Locally decoded settings registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_one_shot  <= 1'b0;
            r_last_idx  <= '0;
            r_dwell     <= '0;
            r_blank_len <= '0;
            r_idle_pat  <= DEFAULT_IDLE;
        end else if (set_stb) begin
            if (set_addr == BASE + OFS_CTRL) begin
                r_enable   <= set_data[CTRL_EN_BIT];
                r_one_shot <= set_data[CTRL_ONESHOT_BIT];
                r_last_idx <= set_data[CTRL_LAST_LSB +: IDX_W];
            end
            if (set_addr == BASE + OFS_DWELL) r_dwell     <= set_data[CNT_W-1:0];
            if (set_addr == BASE + OFS_BLANK) r_blank_len <= set_data[CNT_W-1:0];
            if (set_addr == BASE + OFS_IDLE)  r_idle_pat  <= set_data[PAT_W-1:0];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_d     <= 1'b0;
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_sw        <= DEFAULT_IDLE;
            r_step      <= 1'b0;
            r_wrap      <= 1'b0;
            r_blank     <= 1'b0;
            r_active    <= 1'b0;
            r_dwell_cnt <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_run_d     <= run;
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_sw        <= w_sw_nxt;
            r_step      <= w_step_nxt;
            r_wrap      <= w_wrap_nxt;
            r_blank     <= w_blank_nxt;
            r_active    <= (w_state_nxt != ST_IDLE);
            r_dwell_cnt <= w_dcnt_nxt;
            r_blank_cnt <= w_bcnt_nxt;
        end
    end

    // Next-state logic: step loads sample DWELL/BLANK and the table at the step edge
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_sw_nxt    = r_sw;
        w_step_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_dcnt_nxt  = r_dwell_cnt;
        w_bcnt_nxt  = (r_blank_cnt != '0) ? r_blank_cnt - CNT_W'(1) : '0;
        w_blank_nxt = (r_blank_cnt > CNT_W'(1));
        w_load      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_index_nxt = '0;
                w_sw_nxt    = r_idle_pat;
                w_bcnt_nxt  = '0;
                w_blank_nxt = 1'b0;
                if (!w_halt) begin
                    w_state_nxt = ST_SCAN;
                    w_load      = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_halt) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_dwell_cnt == '0) begin
                    if (r_index < w_last) begin
                        w_load = 1'b1;
                    end else if (!r_one_shot) begin
                        w_load     = 1'b1;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_dcnt_nxt = r_dwell_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (w_halt) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_IDLE && r_state != ST_IDLE) begin
            w_index_nxt = '0;
            w_sw_nxt    = r_idle_pat;
            w_bcnt_nxt  = '0;
            w_blank_nxt = 1'b0;
        end

        if (w_load) begin
            w_index_nxt = w_rd_idx;
            w_sw_nxt    = w_rd_data;
            w_step_nxt  = 1'b1;
            w_dcnt_nxt  = w_dwell_load;
            w_bcnt_nxt  = r_blank_len;
            w_blank_nxt = (r_blank_len != '0);
        end
    end

    assign sw_out    = r_sw;
    assign step_stb  = r_step;
    assign wrap_stb  = r_wrap;
    assign blank     = r_blank;
    assign active    = r_active;
    assign rb_status = {22'b0, r_state, 4'b0, r_index};

endmodule
